// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-chain types, defaults and width helper
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        if (bits == 0) bits = 1;
        return bits;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for the sequential divider
interface seq_divider_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    // One guard bit above the shifted remainder so the borrow lands in the MSB.
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] t;

    always_comb begin
        r_sh   = {r, q_msb};
        t      = r_sh - {2'b00, d};
        q_bit  = ~t[WIDTH+1];
        r_next = q_bit ? t[WIDTH:0] : r_sh[WIDTH:0];
    end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional DIV_ZERO_FAST_EN: zero divisor skips the iteration and completes one edge after accept.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    state_t           state, state_next;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r_step;
    logic             q_bit;
    logic             accept;

    assign accept = bus.in_ready & bus.in_valid;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (FAST_ZERO && (bus.divisor == '0)) state_next = DONE;
                    else                                  state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                if (bus.out_valid && bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            r_q             <= '0;
            q_q             <= '0;
            d_q             <= '0;
            count           <= '0;
        end else begin
            // in_ready is registered so it never depends combinationally on in_valid.
            bus.in_ready <= (state_next == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_q   <= '0;
                        q_q   <= bus.dividend;
                        d_q   <= bus.divisor;
                        count <= '0;
                    end
                end
                BUSY: begin
                    r_q   <= r_step;
                    q_q   <= {q_q[WIDTH-2:0], q_bit};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        bus.quotient    <= {q_q[WIDTH-2:0], q_bit};
                        bus.remainder   <= r_step[WIDTH-1:0];
                        bus.div_by_zero <= (d_q == '0);
                        bus.out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    // Only the zero-divisor shortcut enters DONE with out_valid still low.
                    if (FAST_ZERO && !bus.out_valid) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= q_q;
                        bus.div_by_zero <= 1'b1;
                        bus.out_valid   <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
